// File: rtl/vga_fetch_arbiter.sv
// Framebuffer port arbiter: shares one single-port memory between the CPU bus and
// the scanline fetcher that fills the pixel line buffer during horizontal blanking.
module vga_fetch_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 32,
  parameter int LINE_STRIDE    = 32,
  parameter int FB_BASE        = 0,
  parameter int CPU_SLOT       = 4,
  localparam int LB_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic              fetch_en,
  input  logic [9:0]        fetch_row,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              lb_we,
  output logic [LB_W-1:0]   lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int REM_W = $clog2(WORDS_PER_LINE + 1);
  localparam int CNT_W = $clog2(CPU_SLOT + 1);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  state_t            state;
  logic [REM_W-1:0]  remaining;
  logic [LB_W-1:0]   word_idx;
  logic [ADDR_W-1:0] vid_addr;
  logic [CNT_W-1:0]  vid_cnt;
  logic              stale;      // in-flight video access belongs to an abandoned line

  logic              vid_pending;
  logic              cpu_elig;
  logic              vid_elig;
  logic              grant_vid;
  logic              grant_cpu;
  logic              underrun_evt;
  logic [CNT_W-1:0]  vid_cnt_inc;
  logic [ADDR_W-1:0] arm_addr;

  assign vid_pending  = (remaining != '0);
  assign underrun_evt = fetch_start && (vid_pending || (state == VID));
  assign cpu_elig     = cpu_req && !cpu_ack;
  // A line being re-armed this cycle must not issue one more word of the old line.
  assign vid_elig     = vid_pending && !fetch_start;
  assign grant_vid    = (state == IDLE) && vid_elig &&
                        (!cpu_elig || (vid_cnt != CNT_W'(CPU_SLOT)));
  assign grant_cpu    = (state == IDLE) && cpu_elig && !grant_vid;
  assign vid_cnt_inc  = (vid_cnt == CNT_W'(CPU_SLOT)) ? vid_cnt : vid_cnt + 1'b1;
  assign arm_addr     = ADDR_W'(FB_BASE) + ADDR_W'(fetch_row) * ADDR_W'(LINE_STRIDE);
  assign fetch_busy   = vid_pending || (state == VID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      word_idx  <= '0;
      vid_addr  <= '0;
      vid_cnt   <= '0;
      stale     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lb_we     <= 1'b0;
      lb_waddr  <= '0;
      lb_wdata  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      underrun  <= 1'b0;
    end else begin
      // NOTE: pulses default low and later assignments in this block take precedence;
      // non-blocking updates make the order of these statements the priority order.
      lb_we   <= 1'b0;
      cpu_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_vid) begin
            state    <= VID;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= vid_addr;
            vid_cnt  <= cpu_req ? vid_cnt_inc : '0;
          end else if (grant_cpu) begin
            state     <= CPU;
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            vid_cnt   <= '0;
          end else if (!cpu_req) begin
            vid_cnt <= '0;
          end
        end
        VID: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            stale   <= 1'b0;
            if (!stale && !fetch_start) begin
              lb_we     <= 1'b1;
              lb_waddr  <= word_idx;
              lb_wdata  <= mem_rdata;
              word_idx  <= word_idx + 1'b1;
              vid_addr  <= vid_addr + 1'b1;
              remaining <= remaining - 1'b1;
            end
          end else if (fetch_start) begin
            stale <= 1'b1;
          end
        end
        CPU: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            cpu_ack <= 1'b1;
            if (!mem_we) cpu_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase

      if (fetch_start) begin
        if (fetch_en) begin
          remaining <= REM_W'(WORDS_PER_LINE);
          word_idx  <= '0;
          vid_addr  <= arm_addr;
        end else begin
          remaining <= '0;
        end
      end

      if (underrun_evt)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Self-checking bench for vga_fetch_arbiter: memory responder, line-buffer monitor and
// a line/grant-pattern reference model computed from addresses and word counts.
module tb_vga_fetch_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WPL    = 32;
  localparam int STRIDE = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_start = 1'b0, fetch_en = 1'b0;
  logic [9:0]        fetch_row = '0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              lb_we;
  logic [4:0]        lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic              fetch_busy, underrun;
  logic              underrun_clr = 1'b0;

  // second instance with a high framebuffer base to exercise address wrap
  logic              w_fetch_start = 1'b0, w_fetch_en = 1'b0;
  logic [9:0]        w_fetch_row = '0;
  logic [DATA_W-1:0] w_cpu_rdata, w_mem_wdata, w_lb_wdata;
  logic [DATA_W-1:0] w_mem_rdata = '0;
  logic              w_cpu_ack, w_mem_req, w_mem_we, w_lb_we, w_fetch_busy, w_underrun;
  logic              w_mem_ack = 1'b0;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [4:0]        w_lb_waddr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 0;
  logic [DATA_W-1:0] last_read = '0;

  typedef struct {int cyc; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} acc_t;
  typedef struct {int idx; logic [DATA_W-1:0] data;} lb_t;
  acc_t              log_q[$];
  lb_t               lb_q[$];
  logic [ADDR_W-1:0] wlog_q[$];
  logic [DATA_W-1:0] mem_arr[int];

  vga_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .fetch_en(fetch_en),
    .fetch_row(fetch_row), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  vga_fetch_arbiter #(.FB_BASE('hFC00)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_start(w_fetch_start), .fetch_en(w_fetch_en),
    .fetch_row(w_fetch_row), .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000),
    .cpu_wdata(32'h0), .cpu_rdata(w_cpu_rdata), .cpu_ack(w_cpu_ack), .mem_req(w_mem_req),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
    .mem_ack(w_mem_ack), .lb_we(w_lb_we), .lb_waddr(w_lb_waddr), .lb_wdata(w_lb_wdata),
    .fetch_busy(w_fetch_busy), .underrun(w_underrun), .underrun_clr(1'b0)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [DATA_W-1:0] hash(logic [ADDR_W-1:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  function automatic logic [DATA_W-1:0] rd(logic [ADDR_W-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return hash(a);
  endfunction

  // word i of row r lives at base + r*stride + i, modulo the 16-bit address space
  function automatic logic [ADDR_W-1:0] line_addr(int base, int row, int i);
    return 16'((base + row * STRIDE + i) % 65536);
  endfunction

  // memory responder: acks mem_lat cycles after a request appears, for one cycle
  initial begin : mem_model
    int   wcnt;
    int   scyc;
    bit   started;
    acc_t e;
    wcnt = 0; scyc = 0; started = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        started = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!started) begin
          started = 1;
          wcnt = mem_lat;
          scyc = cyc;
        end
        if (wcnt == 0) begin
          e.cyc = scyc; e.we = mem_we; e.addr = mem_addr; e.wdata = mem_wdata;
          log_q.push_back(e);
          if (mem_we) mem_arr[int'(mem_addr)] = mem_wdata;
          else mem_rdata = rd(mem_addr);
          mem_ack = 1'b1;
          started = 0;
        end else begin
          wcnt--;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n || w_mem_ack) begin
      w_mem_ack = 1'b0;
    end else if (w_mem_req) begin
      wlog_q.push_back(w_mem_addr);
      w_mem_rdata = hash(w_mem_addr);
      w_mem_ack = 1'b1;
    end
  end

  initial begin : lb_monitor
    lb_t e;
    forever begin
      @(negedge clk);
      if (lb_we) begin
        e.idx = int'(lb_waddr);
        e.data = lb_wdata;
        lb_q.push_back(e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(int row, bit en);
    fetch_row = 10'(row);
    fetch_en = en;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (fetch_busy && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done fetch_busy=%b want 0", name, fetch_busy);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int n;
    repeat (3) tick();
    checks++;
    if ({mem_req, mem_we, lb_we, cpu_ack, fetch_busy, underrun} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0 || lb_wdata !== '0 ||
        lb_waddr !== '0) begin
      errors++;
      $display("FAIL reset_in ctl=%b addr=%h rdata=%h want all zero",
               {mem_req, mem_we, lb_we, cpu_ack, fetch_busy, underrun}, mem_addr, cpu_rdata);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({mem_req, lb_we, cpu_ack, fetch_busy, underrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_out ctl=%b want 00000", {mem_req, lb_we, cpu_ack, fetch_busy, underrun});
    end
    mem_lat = 3;
    arm(3, 1'b1);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_req mem_req=%b want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, lb_we, cpu_ack} !== 3'b0) begin
      errors++;
      $display("FAIL reset_async req/lb_we/ack=%b want 000", {mem_req, lb_we, cpu_ack});
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if ({fetch_busy, underrun, mem_req} !== 3'b0) begin
      errors++;
      $display("FAIL reset_release busy/underrun/req=%b want 000", {fetch_busy, underrun, mem_req});
    end
    mem_lat = 0;
    log_q.delete();
    lb_q.delete();
  endtask

  task automatic test_line_fetch(int row, int lat);
    log_q.delete();
    lb_q.delete();
    mem_lat = lat;
    arm(row, 1'b1);
    checks++;
    if (fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL line_busy_rise row=%0d fetch_busy=%b want 1", row, fetch_busy);
    end
    wait_done("line");
    checks++;
    if (log_q.size() != WPL || lb_q.size() != WPL) begin
      errors++;
      $display("FAIL line_count row=%0d accesses=%0d lb_writes=%0d want %0d", row,
               log_q.size(), lb_q.size(), WPL);
    end else begin
      for (int i = 0; i < WPL; i++) begin
        checks++;
        if (log_q[i].addr !== line_addr(0, row, i) || log_q[i].we !== 1'b0) begin
          errors++;
          $display("FAIL line_addr row=%0d i=%0d got %h we=%b want %h we=0", row, i,
                   log_q[i].addr, log_q[i].we, line_addr(0, row, i));
        end
        checks++;
        if (lb_q[i].idx != i || lb_q[i].data !== hash(line_addr(0, row, i))) begin
          errors++;
          $display("FAIL line_lb row=%0d i=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   row, i, lb_q[i].idx, lb_q[i].data, i, hash(line_addr(0, row, i)));
        end
        if (i > 0) begin
          checks++;
          if (log_q[i].cyc - log_q[i-1].cyc != lat + 2) begin
            errors++;
            $display("FAIL line_gap row=%0d i=%0d got %0d want %0d", row, i,
                     log_q[i].cyc - log_q[i-1].cyc, lat + 2);
          end
        end
      end
    end
  endtask

  task automatic test_cpu_read();
    int n;
    log_q.delete();
    mem_lat = 0;
    cpu_we = 1'b0;
    cpu_addr = 16'h1234;
    cpu_req = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h1234) begin
      errors++;
      $display("FAIL cpu_rd_req req=%b we=%b addr=%h want 1 0 1234", mem_req, mem_we, mem_addr);
    end
    tick();
    last_read = rd(16'h1234);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== last_read) begin
      errors++;
      $display("FAIL cpu_rd_ack ack=%b rdata=%h want 1 %h", cpu_ack, cpu_rdata, last_read);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rd_no_regrant ack=%b req=%b want 0 0", cpu_ack, mem_req);
    end
    cpu_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (log_q.size() != 1) begin
      errors++;
      $display("FAIL cpu_rd_count accesses=%0d want 1", log_q.size());
    end
  endtask

  task automatic test_cpu_slot();
    int                row, n, v;
    bit                done;
    logic [ADDR_W-1:0] ca_q[$];
    logic [DATA_W-1:0] cd_q[$];
    log_q.delete();
    lb_q.delete();
    mem_lat = $urandom_range(0, 1);
    row = $urandom_range(0, 1023);
    arm(row, 1'b1);
    cpu_we = 1'b1;
    cpu_addr = 16'h8000 | 16'($urandom_range(0, 32767));
    cpu_wdata = $urandom;
    ca_q.push_back(cpu_addr);
    cd_q.push_back(cpu_wdata);
    cpu_req = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 4000) begin
      tick();
      n++;
      if (cpu_ack) begin
        if (!fetch_busy) begin
          cpu_req = 1'b0;
          done = 1;
        end else begin
          cpu_addr = 16'h8000 | 16'($urandom_range(0, 32767));
          cpu_wdata = $urandom;
          ca_q.push_back(cpu_addr);
          cd_q.push_back(cpu_wdata);
        end
      end
    end
    repeat (4) tick();
    checks++;
    if (!done || log_q.size() != 40 || lb_q.size() != WPL) begin
      errors++;
      $display("FAIL slot_count done=%0d accesses=%0d lb=%0d want 1 40 %0d", done,
               log_q.size(), lb_q.size(), WPL);
    end else begin
      // every fifth grant goes to the waiting CPU
      for (int k = 0; k < 40; k++) begin
        checks++;
        if (k % 5 == 4) begin
          if (log_q[k].we !== 1'b1 || log_q[k].addr !== ca_q[k/5] || log_q[k].wdata !== cd_q[k/5]) begin
            errors++;
            $display("FAIL slot_cpu k=%0d got we=%b addr=%h data=%h want 1 %h %h", k,
                     log_q[k].we, log_q[k].addr, log_q[k].wdata, ca_q[k/5], cd_q[k/5]);
          end
        end else begin
          v = k - k / 5;
          if (log_q[k].we !== 1'b0 || log_q[k].addr !== line_addr(0, row, v)) begin
            errors++;
            $display("FAIL slot_vid k=%0d got we=%b addr=%h want 0 %h", k, log_q[k].we,
                     log_q[k].addr, line_addr(0, row, v));
          end
        end
      end
      for (int i = 0; i < WPL; i++) begin
        checks++;
        if (lb_q[i].idx != i || lb_q[i].data !== hash(line_addr(0, row, i))) begin
          errors++;
          $display("FAIL slot_lb i=%0d got idx=%0d data=%h want %h", i, lb_q[i].idx,
                   lb_q[i].data, hash(line_addr(0, row, i)));
        end
      end
    end
    checks++;
    if (cpu_rdata !== last_read) begin
      errors++;
      $display("FAIL slot_rdata_hold got %h want %h", cpu_rdata, last_read);
    end
  endtask

  task automatic test_underrun();
    int n;
    log_q.delete();
    lb_q.delete();
    mem_lat = 2;
    arm(5, 1'b1);
    n = 0;
    while (lb_q.size() < 10 && n < 500) begin
      tick();
      n++;
    end
    // word 10 of row 5 is in flight here; the new line abandons it
    arm(6, 1'b1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set got %b want 1", underrun);
    end
    wait_done("underrun");
    checks++;
    if (log_q.size() != 43 || lb_q.size() != 42) begin
      errors++;
      $display("FAIL underrun_count accesses=%0d lb=%0d want 43 42", log_q.size(), lb_q.size());
    end else begin
      checks++;
      if (log_q[10].addr !== 16'd170 || log_q[11].addr !== 16'd192) begin
        errors++;
        $display("FAIL underrun_addr inflight=%h next=%h want 00aa 00c0", log_q[10].addr,
                 log_q[11].addr);
      end
      for (int i = 0; i < 42; i++) begin
        checks++;
        if (i < 10) begin
          if (lb_q[i].idx != i || lb_q[i].data !== hash(line_addr(0, 5, i))) begin
            errors++;
            $display("FAIL underrun_old_lb i=%0d got idx=%0d data=%h", i, lb_q[i].idx, lb_q[i].data);
          end
        end else if (lb_q[i].idx != i - 10 || lb_q[i].data !== hash(line_addr(0, 6, i - 10)) ||
                     log_q[i+1].addr !== line_addr(0, 6, i - 10)) begin
          errors++;
          $display("FAIL underrun_new i=%0d got idx=%0d data=%h addr=%h want idx=%0d addr=%h", i,
                   lb_q[i].idx, lb_q[i].data, log_q[i+1].addr, i - 10, line_addr(0, 6, i - 10));
        end
      end
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b want 1", underrun);
    end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clr got %b want 0", underrun);
    end
    arm(7, 1'b1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clean_arm got %b want 0", underrun);
    end
    underrun_clr = 1'b1;
    arm(8, 1'b1);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set_wins got %b want 1", underrun);
    end
    wait_done("underrun2");
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    mem_lat = 0;
  endtask

  task automatic test_wrap_and_disabled();
    int n;
    int row;
    wlog_q.delete();
    w_fetch_row = 10'd1023;
    w_fetch_en = 1'b1;
    w_fetch_start = 1'b1;
    tick();
    w_fetch_start = 1'b0;
    n = 0;
    while (w_fetch_busy && n < 500) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (wlog_q.size() != WPL || w_fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count accesses=%0d busy=%b want %0d 0", wlog_q.size(), w_fetch_busy, WPL);
    end else begin
      for (int i = 0; i < WPL; i++) begin
        checks++;
        if (wlog_q[i] !== line_addr('hFC00, 1023, i)) begin
          errors++;
          $display("FAIL wrap_addr i=%0d got %h want %h", i, wlog_q[i], line_addr('hFC00, 1023, i));
        end
      end
    end
    row = $urandom_range(0, 1023);
    arm(row, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({mem_req, fetch_busy, underrun} !== 3'b0) begin
        errors++;
        $display("FAIL disabled_arm t=%0d req/busy/underrun=%b want 000", i,
                 {mem_req, fetch_busy, underrun});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_line_fetch(5, 0);
    for (int r = 0; r < 3; r++) test_line_fetch($urandom_range(0, 1023), $urandom_range(0, 2));
    test_cpu_read();
    test_cpu_slot();
    test_underrun();
    test_wrap_and_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fetch_arbiter.md
Name: vga_fetch_arbiter

Overview:
- Shares one single-port framebuffer memory interface between the CPU bus and the scanline video fetcher.
- On each horizontal-blanking start pulse from the VGA timing generator, fetches the next row's words into the pixel line buffer.
- Gives video priority, with a guaranteed CPU slot that bounds CPU latency.
- Sits between the timing generator, the line buffer, the CPU peripheral bus and the framebuffer RAM.

Parameters:
ADDR_W, 16, word address width of memory and CPU ports
DATA_W, 32, data width
WORDS_PER_LINE, 32, words fetched per row (1024 px at 1 bpp)
LINE_STRIDE, 32, word stride between rows
FB_BASE, 0, word address of row 0
CPU_SLOT, 4, max consecutive video grants while cpu_req is pending

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fetch_start  in  1  1-cycle pulse at start of horizontal blanking
fetch_en  in  1  level; 0 during vertical blanking, so no fetch is armed
fetch_row  in  10  row to fetch; sampled with fetch_start
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
cpu_ack  out  1  1-cycle completion pulse
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, 1 cycle
lb_we  out  1  line buffer write strobe
lb_waddr  out  clog2(WORDS_PER_LINE)  line buffer word index
lb_wdata  out  DATA_W  line buffer data
fetch_busy  out  1  video words remain or video access in flight
underrun  out  1  sticky: new line started before previous fetch completed
underrun_clr  in  1  clears underrun

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all outputs 0.
  - remaining-word count 0; word index 0; consecutive-video count 0.
- FSM states:
  - IDLE: mem_req=0; arbitrates.
  - VID: mem_req=1, mem_we=0, mem_addr = fetch address.
  - CPU: mem_req=1; mem_we, mem_addr, mem_wdata = latched CPU values.
  - mem_* are stable while mem_req=1.
  - VID or CPU returns to IDLE on the edge where mem_ack=1.
  - This forces at least one idle cycle between transactions.
- Arbitration in IDLE:
  - cpu_req is ignored in any cycle where cpu_ack=1.
  - Video is eligible when remaining > 0. CPU is eligible when cpu_req=1.
  - Both eligible: video wins unless the consecutive-video count equals CPU_SLOT; then CPU wins.
  - Consecutive-video count increments per video grant, saturates at CPU_SLOT, and clears on a CPU grant or whenever cpu_req=0 in IDLE.
  - CPU request fields are latched at grant.
- Fetch arm, on fetch_start=1 with fetch_en=1:
  - remaining = WORDS_PER_LINE; word index = 0.
  - address = FB_BASE + fetch_row*LINE_STRIDE, truncated to ADDR_W (wraps).
  - fetch_start with fetch_en=0 leaves remaining at 0.
- Video completion:
  - Cycle after the mem_ack edge: lb_we=1 for exactly 1 cycle, with lb_waddr = word index and lb_wdata = captured mem_rdata.
  - Then word index +1, address +1 (wraps modulo 2^ADDR_W), remaining −1.
- CPU completion:
  - Cycle after the mem_ack edge: cpu_ack=1 for 1 cycle.
  - On a read, cpu_rdata = captured mem_rdata; it holds until the next CPU read ack.
  - On a write, cpu_rdata is unchanged.
- Underrun (fetch_start with remaining > 0 or a video access in flight):
  - underrun sets to 1, regardless of fetch_en.
  - Remaining words of the old line are abandoned.
  - An in-flight old-line access completes on the memory bus but produces no lb_we.
  - The new arm (if fetch_en=1) takes effect the same cycle; its first grant is at the next IDLE.
- underrun_clr:
  - Clears underrun on the next edge.
  - If underrun_clr and a new underrun event occur in the same cycle, set wins.
- fetch_busy = (remaining > 0) or (state == VID).
- An in-flight CPU access is never aborted by fetch_start.

Test Plan:
- Reset mid-transaction (rst_n low while in VID with mem_req=1) -> mem_req, lb_we and cpu_ack drop immediately (asynchronous); fetch_busy=0 and underrun=0 after release.
- fetch_start, fetch_en=1, fetch_row=5, FB_BASE=0, memory acks in 1 cycle, no CPU traffic:
  - mem_addr sequence 160..191, one idle cycle between requests.
  - 32 lb_we pulses with lb_waddr 0..31 and matching data.
  - fetch_busy falls after the last word.
- CPU read at address 0x1234 with no video pending -> mem_we=0, mem_addr=0x1234; cpu_ack 1 cycle after mem_ack with cpu_rdata = memory value; cpu_req still high in the ack cycle is not re-granted.
- Video line armed and cpu_req held continuously -> grant pattern V,V,V,V,C,V,V,V,V,C...; CPU write data appears on mem_wdata with mem_we=1.
- Second fetch_start (row 6) after only 10 words of row 5 have completed:
  - underrun=1; no further row-5 lb_we.
  - Next mem_addr is 192 and lb_waddr restarts at 0.
  - underrun_clr returns underrun to 0.
- fetch_row=1023 with FB_BASE=0xFC00 -> address wraps modulo 2^16 (0xFC00+32736 -> 0x7BE0); fetch_start with fetch_en=0 -> no mem_req, fetch_busy stays 0.
